// File: rtl/vga_vram_arbiter_if.sv
// Signal bundle between the VGA VRAM arbiter, the display fetch/host ports and the VRAM macro.
// slave: arbiter side; master: environment side (display, host, memory).
interface vga_vram_arbiter_if #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned STALL_W = 16
);
    logic               activevideo_i;
    logic               disp_req_i;
    logic [ADDR_W-1:0]  disp_addr_i;
    logic               disp_valid_o;
    logic [DATA_W-1:0]  disp_data_o;
    logic               host_req_i;
    logic               host_we_i;
    logic [ADDR_W-1:0]  host_addr_i;
    logic [DATA_W-1:0]  host_wdata_i;
    logic               host_ack_o;
    logic               host_rvalid_o;
    logic [DATA_W-1:0]  host_rdata_o;
    logic               mem_en_o;
    logic               mem_we_o;
    logic [ADDR_W-1:0]  mem_addr_o;
    logic [DATA_W-1:0]  mem_wdata_o;
    logic [DATA_W-1:0]  mem_rdata_i;
    logic               stall_clr_i;
    logic [STALL_W-1:0] host_stall_o;

    modport slave (
        input  activevideo_i, disp_req_i, disp_addr_i,
        input  host_req_i, host_we_i, host_addr_i, host_wdata_i,
        input  mem_rdata_i, stall_clr_i,
        output disp_valid_o, disp_data_o,
        output host_ack_o, host_rvalid_o, host_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output host_stall_o
    );

    modport master (
        output activevideo_i, disp_req_i, disp_addr_i,
        output host_req_i, host_we_i, host_addr_i, host_wdata_i,
        output mem_rdata_i, stall_clr_i,
        input  disp_valid_o, disp_data_o,
        input  host_ack_o, host_rvalid_o, host_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  host_stall_o
    );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display reads have strict priority, host reads/writes fill idle slots.
// Define VGA_ARB_BLANK_ONLY_EN to restrict host service to blanking (activevideo_i=0).
module vga_vram_arbiter #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned STALL_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    vga_vram_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, DISP, HOST_WR, HOST_RD} state_e;

    state_e             state_q, state_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               host_ack_q, host_ack_d;
    logic [1:0]         tag1_q, tag1_d;
    logic [1:0]         tag2_q, tag2_d;
    logic               disp_valid_q, disp_valid_d;
    logic [DATA_W-1:0]  disp_data_q, disp_data_d;
    logic               host_rvalid_q, host_rvalid_d;
    logic [DATA_W-1:0]  host_rdata_q, host_rdata_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               host_gate_c;
    logic               host_busy_c;
    logic               host_grant_c;

`ifdef VGA_ARB_BLANK_ONLY_EN
    assign host_gate_c = ~bus.activevideo_i;
`else
    logic unused_activevideo;
    assign unused_activevideo = bus.activevideo_i;
    assign host_gate_c = 1'b1;
`endif

    // The cycle carrying host_ack_o never re-grants the host.
    assign host_busy_c = (state_q == HOST_WR) || (state_q == HOST_RD);

    // Issue decision plus tag/return pipeline and stall counter.
    always_comb begin
        state_d       = IDLE;
        mem_en_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        host_ack_d    = 1'b0;
        host_grant_c  = 1'b0;
        stall_d       = stall_q;

        if (bus.disp_req_i) begin
            state_d    = DISP;
            mem_en_d   = 1'b1;
            mem_addr_d = bus.disp_addr_i;
        end else if (bus.host_req_i && !host_busy_c && host_gate_c) begin
            state_d      = bus.host_we_i ? HOST_WR : HOST_RD;
            mem_en_d     = 1'b1;
            mem_we_d     = bus.host_we_i;
            mem_addr_d   = bus.host_addr_i;
            mem_wdata_d  = bus.host_wdata_i;
            host_ack_d   = 1'b1;
            host_grant_c = 1'b1;
        end

        // tag bit 1: display read, bit 0: host read
        tag1_d = {state_d == DISP, state_d == HOST_RD};
        tag2_d = tag1_q;

        disp_valid_d  = tag2_q[1];
        disp_data_d   = tag2_q[1] ? bus.mem_rdata_i : disp_data_q;
        host_rvalid_d = tag2_q[0];
        host_rdata_d  = tag2_q[0] ? bus.mem_rdata_i : host_rdata_q;

        if (bus.stall_clr_i) begin
            stall_d = '0;
        end else if (bus.host_req_i && !host_busy_c && !host_grant_c && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            host_ack_q    <= 1'b0;
            tag1_q        <= 2'b00;
            tag2_q        <= 2'b00;
            disp_valid_q  <= 1'b0;
            disp_data_q   <= '0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
            stall_q       <= '0;
        end else begin
            state_q       <= state_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            host_ack_q    <= host_ack_d;
            tag1_q        <= tag1_d;
            tag2_q        <= tag2_d;
            disp_valid_q  <= disp_valid_d;
            disp_data_q   <= disp_data_d;
            host_rvalid_q <= host_rvalid_d;
            host_rdata_q  <= host_rdata_d;
            stall_q       <= stall_d;
        end
    end

    assign bus.mem_en_o      = mem_en_q;
    assign bus.mem_we_o      = mem_we_q;
    assign bus.mem_addr_o    = mem_addr_q;
    assign bus.mem_wdata_o   = mem_wdata_q;
    assign bus.host_ack_o    = host_ack_q;
    assign bus.disp_valid_o  = disp_valid_q;
    assign bus.disp_data_o   = disp_data_q;
    assign bus.host_rvalid_o = host_rvalid_q;
    assign bus.host_rdata_o  = host_rdata_q;
    assign bus.host_stall_o  = stall_q;
endmodule
